// File: rtl/mem_stage.sv
// Memory-access pipeline stage: takes the ex->mem bundle, runs loads and
// stores over a req/ack data bus, extends load data and registers the
// mem->wb bundle. Upstream is stalled while a bus transaction is open.
module mem_stage #(
  parameter int DMEM_AW = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_ex_mem_valid,
  input  logic               i_ex_mem_load,
  input  logic               i_ex_mem_store,
  input  logic [2:0]         i_ex_mem_funct3,
  input  logic [31:0]        i_ex_mem_addr,
  input  logic [31:0]        i_ex_mem_wdata,
  input  logic [31:0]        i_ex_mem_result,
  input  logic               i_ex_mem_writeback,
  input  logic [5:0]         i_ex_mem_rd,
  output logic               o_mem_stall,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [DMEM_AW-1:0] o_dmem_addr,
  output logic [31:0]        o_dmem_wdata,
  output logic [3:0]         o_dmem_be,
  input  logic               i_dmem_ack,
  input  logic [31:0]        i_dmem_rdata,
  output logic               o_mem_fault,
  output logic               o_mem_wb_writeback,
  output logic [31:0]        o_mem_wb_data,
  output logic [5:0]         o_mem_wb_rd
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  state_e      state_q, state_d;

  // Latched memory operation, held stable for the whole bus transaction.
  logic [31:0] op_addr_q, op_addr_d;
  logic [31:0] op_wdata_q, op_wdata_d;
  logic [3:0]  op_be_q, op_be_d;
  logic [2:0]  op_funct3_q, op_funct3_d;
  logic        op_store_q, op_store_d;
  logic        op_wb_q, op_wb_d;
  logic [5:0]  op_rd_q, op_rd_d;

  // Registered mem->wb bundle and fault pulse.
  logic        wb_q, wb_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [5:0]  wb_rd_q, wb_rd_d;
  logic        fault_q, fault_d;

  // Decode of the incoming instruction.
  logic        is_mem;
  logic        size_ok;
  logic        misaligned;
  logic        access_fault;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;
  logic        busy;
  logic [31:0] bus_addr;

  assign busy = (state_q == S_BUSY);

  // Legality, alignment and store lane formatting of the incoming op.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    size_ok    = 1'b0;
    misaligned = 1'b0;
    st_wdata   = i_ex_mem_wdata;
    st_be      = 4'b1111;
    is_mem     = i_ex_mem_load | i_ex_mem_store;
    unique case (i_ex_mem_funct3)
      3'b000, 3'b001, 3'b010: size_ok = 1'b1;
      3'b100, 3'b101:         size_ok = ~i_ex_mem_store;
      default:                size_ok = 1'b0;
    endcase
    if (i_ex_mem_funct3[1:0] == 2'b01) misaligned = i_ex_mem_addr[0];
    if (i_ex_mem_funct3[1:0] == 2'b10) misaligned = (i_ex_mem_addr[1:0] != 2'b00);
    access_fault = ~size_ok | misaligned;
    unique case (i_ex_mem_funct3[1:0])
      2'b00: begin
        st_wdata = {4{i_ex_mem_wdata[7:0]}};
        st_be    = 4'b0001 << i_ex_mem_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{i_ex_mem_wdata[15:0]}};
        st_be    = 4'b0011 << i_ex_mem_addr[1:0];
      end
      default: begin
        st_wdata = i_ex_mem_wdata;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Lane select and sign/zero extension of the returned read word.
  always_comb begin
    logic [31:0] byte_word;
    logic [31:0] half_word;
    byte_word = i_dmem_rdata >> {op_addr_q[1:0], 3'b000};
    half_word = i_dmem_rdata >> {op_addr_q[1], 4'b0000};
    ld_data   = i_dmem_rdata;
    unique case (op_funct3_q)
      3'b000:  ld_data = {{24{byte_word[7]}}, byte_word[7:0]};
      3'b001:  ld_data = {{16{half_word[15]}}, half_word[15:0]};
      3'b100:  ld_data = {24'b0, byte_word[7:0]};
      3'b101:  ld_data = {16'b0, half_word[15:0]};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  // Next-state logic: accept a legal memory op in IDLE, leave BUSY on ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (i_ex_mem_valid && is_mem && !access_fault) state_d = S_BUSY;
      S_BUSY:  if (i_dmem_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: op latch and the mem->wb bundle.
  always_comb begin
    op_addr_d   = op_addr_q;
    op_wdata_d  = op_wdata_q;
    op_be_d     = op_be_q;
    op_funct3_d = op_funct3_q;
    op_store_d  = op_store_q;
    op_wb_d     = op_wb_q;
    op_rd_d     = op_rd_q;
    wb_d        = 1'b0;
    wb_data_d   = i_ex_mem_result;
    wb_rd_d     = i_ex_mem_rd;
    fault_d     = 1'b0;
    if (state_q == S_IDLE) begin
      if (i_ex_mem_valid && !is_mem) begin
        wb_d = i_ex_mem_writeback;
      end else if (i_ex_mem_valid && access_fault) begin
        fault_d = 1'b1;
      end else if (i_ex_mem_valid) begin
        // Store takes priority when both load and store are flagged.
        op_addr_d   = i_ex_mem_addr;
        op_wdata_d  = st_wdata;
        op_be_d     = i_ex_mem_store ? st_be : 4'b1111;
        op_funct3_d = i_ex_mem_funct3;
        op_store_d  = i_ex_mem_store;
        op_wb_d     = i_ex_mem_writeback;
        op_rd_d     = i_ex_mem_rd;
      end
    end else begin
      wb_data_d = wb_data_q;
      wb_rd_d   = wb_rd_q;
      if (i_dmem_ack && !op_store_q) begin
        wb_d      = op_wb_q;
        wb_data_d = ld_data;
        wb_rd_d   = op_rd_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      op_addr_q   <= '0;
      op_wdata_q  <= '0;
      op_be_q     <= '0;
      op_funct3_q <= '0;
      op_store_q  <= 1'b0;
      op_wb_q     <= 1'b0;
      op_rd_q     <= '0;
      wb_q        <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      fault_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      op_addr_q   <= op_addr_d;
      op_wdata_q  <= op_wdata_d;
      op_be_q     <= op_be_d;
      op_funct3_q <= op_funct3_d;
      op_store_q  <= op_store_d;
      op_wb_q     <= op_wb_d;
      op_rd_q     <= op_rd_d;
      wb_q        <= wb_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      fault_q     <= fault_d;
    end
  end

  // Outputs: bus signals come from state and the op latch only, so reset
  // drops the request immediately.
  assign o_mem_stall        = busy;
  assign o_dmem_req         = busy;
  assign o_dmem_we          = busy & op_store_q;
  assign o_dmem_wdata       = busy ? op_wdata_q : 32'b0;
  assign o_dmem_be          = busy ? op_be_q : 4'b0;
  assign bus_addr           = busy ? {op_addr_q[31:2], 2'b00} : 32'b0;
  assign o_mem_fault        = fault_q;
  assign o_mem_wb_writeback = wb_q;
  assign o_mem_wb_data      = wb_data_q;
  assign o_mem_wb_rd        = wb_rd_q;

  if (DMEM_AW > 32) begin : g_addr_wide
    assign o_dmem_addr = {{(DMEM_AW - 32){1'b0}}, bus_addr};
  end else begin : g_addr_narrow
    assign o_dmem_addr = bus_addr[DMEM_AW-1:0];
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with hand-computed expected values.
module tb_mem_stage;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_ex_mem_valid;
  logic        i_ex_mem_load;
  logic        i_ex_mem_store;
  logic [2:0]  i_ex_mem_funct3;
  logic [31:0] i_ex_mem_addr;
  logic [31:0] i_ex_mem_wdata;
  logic [31:0] i_ex_mem_result;
  logic        i_ex_mem_writeback;
  logic [5:0]  i_ex_mem_rd;
  logic        o_mem_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_mem_fault;
  logic        o_mem_wb_writeback;
  logic [31:0] o_mem_wb_data;
  logic [5:0]  o_mem_wb_rd;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_stage #(.DMEM_AW(32)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_ex_mem_valid     (i_ex_mem_valid),
    .i_ex_mem_load      (i_ex_mem_load),
    .i_ex_mem_store     (i_ex_mem_store),
    .i_ex_mem_funct3    (i_ex_mem_funct3),
    .i_ex_mem_addr      (i_ex_mem_addr),
    .i_ex_mem_wdata     (i_ex_mem_wdata),
    .i_ex_mem_result    (i_ex_mem_result),
    .i_ex_mem_writeback (i_ex_mem_writeback),
    .i_ex_mem_rd        (i_ex_mem_rd),
    .o_mem_stall        (o_mem_stall),
    .o_dmem_req         (o_dmem_req),
    .o_dmem_we          (o_dmem_we),
    .o_dmem_addr        (o_dmem_addr),
    .o_dmem_wdata       (o_dmem_wdata),
    .o_dmem_be          (o_dmem_be),
    .i_dmem_ack         (i_dmem_ack),
    .i_dmem_rdata       (i_dmem_rdata),
    .o_mem_fault        (o_mem_fault),
    .o_mem_wb_writeback (o_mem_wb_writeback),
    .o_mem_wb_data      (o_mem_wb_data),
    .o_mem_wb_rd        (o_mem_wb_rd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_op(input logic valid, input logic ld, input logic st,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] result,
                          input logic wb, input logic [5:0] rd);
    i_ex_mem_valid     = valid;
    i_ex_mem_load      = ld;
    i_ex_mem_store     = st;
    i_ex_mem_funct3    = f3;
    i_ex_mem_addr      = addr;
    i_ex_mem_wdata     = wdata;
    i_ex_mem_result    = result;
    i_ex_mem_writeback = wb;
    i_ex_mem_rd        = rd;
  endtask

  task automatic idle_in();
    drive_op(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 6'd0);
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_dmem_ack   = 1'b0;
    i_dmem_rdata = 32'h0;
    idle_in();
    #2;
    check("rst_stall", {31'b0, o_mem_stall}, 32'd0);
    check("rst_req",   {31'b0, o_dmem_req}, 32'd0);
    check("rst_fault", {31'b0, o_mem_fault}, 32'd0);
    check("rst_wb",    {31'b0, o_mem_wb_writeback}, 32'd0);
    check("rst_data",  o_mem_wb_data, 32'd0);
    check("rst_rd",    {26'b0, o_mem_wb_rd}, 32'd0);
    check("rst_addr",  o_dmem_addr, 32'd0);
    #10 i_rst_n = 1'b1;
    step();

    // ALU passthrough
    drive_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1234_5678, 1'b1, 6'd5);
    #1 check("alu_stall_pre", {31'b0, o_mem_stall}, 32'd0);
    step();
    check("alu_wb",    {31'b0, o_mem_wb_writeback}, 32'd1);
    check("alu_data",  o_mem_wb_data, 32'h1234_5678);
    check("alu_rd",    {26'b0, o_mem_wb_rd}, 32'd5);
    check("alu_stall", {31'b0, o_mem_stall}, 32'd0);
    idle_in();
    step();
    check("bubble_wb", {31'b0, o_mem_wb_writeback}, 32'd0);

    // LB sign-extend, ack one cycle after req
    drive_op(1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h0, 1'b1, 6'd7);
    step();
    idle_in();
    check("lb_req",   {31'b0, o_dmem_req}, 32'd1);
    check("lb_we",    {31'b0, o_dmem_we}, 32'd0);
    check("lb_addr",  o_dmem_addr, 32'h100);
    check("lb_stall", {31'b0, o_mem_stall}, 32'd1);
    check("lb_wb0",   {31'b0, o_mem_wb_writeback}, 32'd0);
    step();
    check("lb_req2",  {31'b0, o_dmem_req}, 32'd1);
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h80FF_0102;
    #1 check("lb_stall_ack", {31'b0, o_mem_stall}, 32'd1);
    step();
    i_dmem_ack = 1'b0;
    check("lb_wb",   {31'b0, o_mem_wb_writeback}, 32'd1);
    check("lb_data", o_mem_wb_data, 32'hFFFF_FF80);
    check("lb_rd",   {26'b0, o_mem_wb_rd}, 32'd7);
    check("lb_req_off", {31'b0, o_dmem_req}, 32'd0);

    // LHU with 3 wait states; next op held upstream during BUSY
    drive_op(1'b1, 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h0, 1'b1, 6'd8);
    step();
    drive_op(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_CAFE, 1'b1, 6'd9);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("lhu_req_c%0d", c),   {31'b0, o_dmem_req}, 32'd1);
      check($sformatf("lhu_addr_c%0d", c),  o_dmem_addr, 32'h200);
      check($sformatf("lhu_stall_c%0d", c), {31'b0, o_mem_stall}, 32'd1);
      check($sformatf("lhu_wb0_c%0d", c),   {31'b0, o_mem_wb_writeback}, 32'd0);
      if (c == 3) begin
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hBEEF_1234;
      end
      step();
    end
    i_dmem_ack = 1'b0;
    check("lhu_wb",    {31'b0, o_mem_wb_writeback}, 32'd1);
    check("lhu_data",  o_mem_wb_data, 32'h0000_BEEF);
    check("lhu_rd",    {26'b0, o_mem_wb_rd}, 32'd8);
    check("lhu_req_off", {31'b0, o_dmem_req}, 32'd0);
    step();
    idle_in();
    check("held_wb",   {31'b0, o_mem_wb_writeback}, 32'd1);
    check("held_data", o_mem_wb_data, 32'h0000_CAFE);
    check("held_rd",   {26'b0, o_mem_wb_rd}, 32'd9);

    // SB at offset 1, same-cycle ack
    drive_op(1'b1, 1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_00A5, 32'h0, 1'b1, 6'd3);
    step();
    idle_in();
    check("sb_req",   {31'b0, o_dmem_req}, 32'd1);
    check("sb_we",    {31'b0, o_dmem_we}, 32'd1);
    check("sb_addr",  o_dmem_addr, 32'h300);
    check("sb_wdata", o_dmem_wdata, 32'hA5A5_A5A5);
    check("sb_be",    {28'b0, o_dmem_be}, 32'h2);
    check("sb_wb0",   {31'b0, o_mem_wb_writeback}, 32'd0);
    i_dmem_ack = 1'b1;
    step();
    i_dmem_ack = 1'b0;
    check("sb_wb1",    {31'b0, o_mem_wb_writeback}, 32'd0);
    check("sb_req_off", {31'b0, o_dmem_req}, 32'd0);

    // SH at offset 2 with load flag also set: store wins
    drive_op(1'b1, 1'b1, 1'b1, 3'b001, 32'h302, 32'h1234_BEEF, 32'h0, 1'b1, 6'd4);
    step();
    idle_in();
    check("sh_we",    {31'b0, o_dmem_we}, 32'd1);
    check("sh_wdata", o_dmem_wdata, 32'hBEEF_BEEF);
    check("sh_be",    {28'b0, o_dmem_be}, 32'hC);
    i_dmem_ack = 1'b1;
    step();
    i_dmem_ack = 1'b0;
    check("sh_wb", {31'b0, o_mem_wb_writeback}, 32'd0);

    // Misaligned LW
    drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h402, 32'h0, 32'h0, 1'b1, 6'd6);
    step();
    idle_in();
    check("lw_mis_fault", {31'b0, o_mem_fault}, 32'd1);
    check("lw_mis_req",   {31'b0, o_dmem_req}, 32'd0);
    check("lw_mis_stall", {31'b0, o_mem_stall}, 32'd0);
    check("lw_mis_wb",    {31'b0, o_mem_wb_writeback}, 32'd0);
    step();
    check("lw_mis_pulse", {31'b0, o_mem_fault}, 32'd0);

    // Store with unsigned size is illegal
    drive_op(1'b1, 1'b0, 1'b1, 3'b100, 32'h500, 32'h0, 32'h0, 1'b0, 6'd1);
    step();
    idle_in();
    check("sbu_fault", {31'b0, o_mem_fault}, 32'd1);
    check("sbu_req",   {31'b0, o_dmem_req}, 32'd0);

    // Stray ack in IDLE is ignored
    i_dmem_ack = 1'b1;
    step();
    i_dmem_ack = 1'b0;
    check("stray_idle_wb",  {31'b0, o_mem_wb_writeback}, 32'd0);
    check("stray_idle_req", {31'b0, o_dmem_req}, 32'd0);

    // Reset asserted mid-BUSY
    drive_op(1'b1, 1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h0, 1'b1, 6'd10);
    step();
    idle_in();
    check("rstb_req_pre", {31'b0, o_dmem_req}, 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    check("rstb_req",   {31'b0, o_dmem_req}, 32'd0);
    check("rstb_stall", {31'b0, o_mem_stall}, 32'd0);
    #2 i_rst_n = 1'b1;
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'h1111_2222;
    step();
    i_dmem_ack = 1'b0;
    check("rstb_ack_wb",  {31'b0, o_mem_wb_writeback}, 32'd0);
    check("rstb_ack_req", {31'b0, o_dmem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
